quad_mem_seq: RTL and testbench

Quad-access sequencer sitting directly upstream of the quad-cell memory. Accepts whole-quad read/write requests over a valid/ready handshake and performs four single-field memory accesses (T, X, Y, Z). Drives the memory's bank selects, write strobe, address, field and write data, and collects the read data into one packed quad response.

---
 rtl/quad_pkg.sv | 33 +++
 rtl/quad_rd_pipe.sv | 26 ++
 rtl/quad_mem_seq.sv | 150 +++++++++++++++
 tb/tb_quad_mem_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared codes and types for the quad-access sequencer
package quad_pkg;

  typedef enum logic [1:0] {
    BANK_RAM     = 2'd0,
    BANK_ROM0    = 2'd1,
    BANK_ROM1    = 2'd2,
    BANK_ILLEGAL = 2'd3
  } bank_e;

  typedef enum logic [1:0] {
    FIELD_T = 2'd0,
    FIELD_X = 2'd1,
    FIELD_Y = 2'd2,
    FIELD_Z = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Number of field slots packed into one quad word
  localparam int FIELD_CNT = 4;

  typedef struct packed {
    logic   vld;
    field_e field;
  } rd_tag_t;

endpackage

// File: rtl/quad_rd_pipe.sv
// rtl/quad_rd_pipe.sv - RD_LAT-deep read tag delay line, aligns field tags with memory read data
module quad_rd_pipe
  import quad_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    i_clk,
  input  logic    clr_n,
  input  rd_tag_t push_tag,
  output rd_tag_t pop_tag
);

  rd_tag_t pipe [RD_LAT];

  always_ff @(posedge i_clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= push_tag;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pop_tag = pipe[RD_LAT-1];

endmodule

// File: rtl/quad_mem_seq.sv
// rtl/quad_mem_seq.sv - whole-quad request sequencer driving four single-field memory accesses
// Define QUAD_ROM_WP_EN to reject writes to the ROM banks.
module quad_mem_seq
  import quad_pkg::*;
#(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 12,
  parameter int RD_LAT  = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic                           i_req_wr,
  input  logic [1:0]                     i_req_bank,
  input  logic [ADDR_SZ-1:0]             i_req_addr,
  input  logic [FIELD_CNT*DATA_SZ-1:0]   i_req_quad,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [FIELD_CNT*DATA_SZ-1:0]   o_rsp_quad,
  output logic                           o_rsp_err,
  output logic                           o_mem_cs_ram,
  output logic                           o_mem_cs_rom0,
  output logic                           o_mem_cs_rom1,
  output logic                           o_mem_wr,
  output logic [ADDR_SZ-1:0]             o_mem_addr,
  output logic [1:0]                     o_mem_field,
  output logic [DATA_SZ-1:0]             o_mem_data,
  input  logic [DATA_SZ-1:0]             i_mem_data
);

  localparam int QUAD_W = FIELD_CNT * DATA_SZ;

  seq_state_e        state;
  logic              wr_q;
  logic [QUAD_W-1:0] quad_q;
  bank_e             req_bank;
  logic              req_reject;
  rd_tag_t           push_tag;
  rd_tag_t           pop_tag;

  assign req_bank = bank_e'(i_req_bank);

`ifdef QUAD_ROM_WP_EN
  assign req_reject = (req_bank == BANK_ILLEGAL) ||
                      (i_req_wr && (req_bank == BANK_ROM0 || req_bank == BANK_ROM1));
`else
  assign req_reject = (req_bank == BANK_ILLEGAL);
`endif

  // Tag enters alongside the field on the bus so it emerges with that field's data
  assign push_tag = '{vld: (state == ST_ISSUE) && !wr_q, field: field_e'(o_mem_field)};

  quad_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .i_clk    (i_clk),
    .clr_n    (i_rst_n),
    .push_tag (push_tag),
    .pop_tag  (pop_tag)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      wr_q          <= 1'b0;
      quad_q        <= '0;
      o_req_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_err     <= 1'b0;
      o_rsp_quad    <= '0;
      o_mem_cs_ram  <= 1'b0;
      o_mem_cs_rom0 <= 1'b0;
      o_mem_cs_rom1 <= 1'b0;
      o_mem_wr      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_field   <= '0;
      o_mem_data    <= '0;
    end else begin
      if (pop_tag.vld)
        o_rsp_quad[int'(pop_tag.field)*DATA_SZ +: DATA_SZ] <= i_mem_data;

      case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            wr_q        <= i_req_wr;
            quad_q      <= i_req_quad;
            o_rsp_quad  <= '0;
            o_req_ready <= 1'b0;
            o_mem_addr  <= i_req_addr;
            if (req_reject) begin
              state       <= ST_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
            end else begin
              state         <= ST_ISSUE;
              o_rsp_err     <= 1'b0;
              o_mem_cs_ram  <= (req_bank == BANK_RAM);
              o_mem_cs_rom0 <= (req_bank == BANK_ROM0);
              o_mem_cs_rom1 <= (req_bank == BANK_ROM1);
              o_mem_wr      <= i_req_wr;
              o_mem_field   <= FIELD_T;
              o_mem_data    <= i_req_quad[DATA_SZ-1:0];
            end
          end
        end

        ST_ISSUE: begin
          if (o_mem_field == FIELD_Z) begin
            o_mem_wr   <= 1'b0;
            o_mem_data <= '0;
            if (wr_q) begin
              state         <= ST_RESP;
              o_rsp_valid   <= 1'b1;
              o_mem_cs_ram  <= 1'b0;
              o_mem_cs_rom0 <= 1'b0;
              o_mem_cs_rom1 <= 1'b0;
            end else begin
              // Select stays up: the memory output register only loads while selected
              state <= ST_DRAIN;
            end
          end else begin
            o_mem_field <= o_mem_field + 2'd1;
            o_mem_data  <= quad_q[(int'(o_mem_field) + 1)*DATA_SZ +: DATA_SZ];
          end
        end

        ST_DRAIN: begin
          if (pop_tag.vld && pop_tag.field == FIELD_Z) begin
            state         <= ST_RESP;
            o_rsp_valid   <= 1'b1;
            o_mem_cs_ram  <= 1'b0;
            o_mem_cs_rom0 <= 1'b0;
            o_mem_cs_rom1 <= 1'b0;
          end
        end

        ST_RESP: begin
          if (i_rsp_ready) begin
            state       <= ST_IDLE;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_req_ready <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_mem_seq.sv
// tb/tb_quad_mem_seq.sv - randomized bench for quad_mem_seq against a quad-level reference model
module tb_quad_mem_seq;

  localparam int DATA_SZ = 16;
  localparam int ADDR_SZ = 12;
  localparam int RD_LAT  = 2;
`ifdef QUAD_ROM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_req_valid;
  logic                 o_req_ready;
  logic                 i_req_wr;
  logic [1:0]           i_req_bank;
  logic [ADDR_SZ-1:0]   i_req_addr;
  logic [4*DATA_SZ-1:0] i_req_quad;
  logic                 o_rsp_valid;
  logic                 i_rsp_ready;
  logic [4*DATA_SZ-1:0] o_rsp_quad;
  logic                 o_rsp_err;
  logic                 o_mem_cs_ram;
  logic                 o_mem_cs_rom0;
  logic                 o_mem_cs_rom1;
  logic                 o_mem_wr;
  logic [ADDR_SZ-1:0]   o_mem_addr;
  logic [1:0]           o_mem_field;
  logic [DATA_SZ-1:0]   o_mem_data;
  logic [DATA_SZ-1:0]   i_mem_data;

  quad_mem_seq #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ), .RD_LAT(RD_LAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
    .i_req_bank(i_req_bank), .i_req_addr(i_req_addr), .i_req_quad(i_req_quad),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_quad(o_rsp_quad),
    .o_rsp_err(o_rsp_err), .o_mem_cs_ram(o_mem_cs_ram), .o_mem_cs_rom0(o_mem_cs_rom0),
    .o_mem_cs_rom1(o_mem_cs_rom1), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
    .o_mem_field(o_mem_field), .o_mem_data(o_mem_data), .i_mem_data(i_mem_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: per-field storage, output register advances only while selected
  logic [63:0] mem_arr [int];
  logic [63:0] ref_arr [int];
  logic [DATA_SZ-1:0] rd_pipe [RD_LAT];
  int cs_cnt [3] = '{0, 0, 0};
  int multi_cs = 0;
  int mkey;
  logic [63:0] mword;
  logic any_cs;
  int cur_bank;

  assign any_cs = o_mem_cs_ram | o_mem_cs_rom0 | o_mem_cs_rom1;
  assign cur_bank = o_mem_cs_rom0 ? 1 : (o_mem_cs_rom1 ? 2 : 0);
  assign i_mem_data = rd_pipe[RD_LAT-1];

  always @(posedge i_clk) begin
    if (o_mem_cs_ram)  cs_cnt[0]++;
    if (o_mem_cs_rom0) cs_cnt[1]++;
    if (o_mem_cs_rom1) cs_cnt[2]++;
    if (int'(o_mem_cs_ram) + int'(o_mem_cs_rom0) + int'(o_mem_cs_rom1) > 1) multi_cs++;
    if (any_cs) begin
      mkey  = cur_bank * 4096 + int'(o_mem_addr);
      mword = mem_arr.exists(mkey) ? mem_arr[mkey] : 64'h0;
      if (o_mem_wr) begin
        mword[o_mem_field*16 +: 16] = o_mem_data;
        mem_arr[mkey] = mword;
      end
      rd_pipe[0] <= o_mem_wr ? 16'hBAD0 : mword[o_mem_field*16 +: 16];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] bank, input logic [11:0] addr,
                        input logic [63:0] quad, input int stall, input string tag);
    int cyc, key, exp_lat, exp_cs, base_multi, base_tot;
    int base [3];
    bit exp_err;
    logic [63:0] exp_q;
    key     = int'(bank) * 4096 + int'(addr);
    exp_err = (bank == 2'd3) || (WP && wr && bank != 2'd0);
    exp_q   = (exp_err || wr) ? 64'h0 : (ref_arr.exists(key) ? ref_arr[key] : 64'h0);
    exp_lat = exp_err ? 1 : (wr ? 5 : 5 + RD_LAT);
    exp_cs  = exp_err ? 0 : (wr ? 4 : 4 + RD_LAT);
    @(negedge i_clk);
    check_eq({tag, " req_ready"}, o_req_ready, 1);
    base       = cs_cnt;
    base_multi = multi_cs;
    base_tot   = cs_cnt[0] + cs_cnt[1] + cs_cnt[2];
    i_req_valid = 1'b1; i_req_wr = wr; i_req_bank = bank; i_req_addr = addr; i_req_quad = quad;
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_req_quad  = {$urandom, $urandom};
    i_req_addr  = 12'($urandom);
    cyc = 1;
    while (!o_rsp_valid && cyc < 60) begin
      @(negedge i_clk);
      cyc++;
    end
    check_eq({tag, " latency"}, cyc, exp_lat);
    check_eq({tag, " err"}, o_rsp_err, exp_err);
    check_eq({tag, " quad"}, o_rsp_quad, exp_q);
    for (int i = 0; i < stall; i++) begin
      @(negedge i_clk);
      check_eq({tag, " held valid/ready"}, {o_rsp_valid, o_req_ready}, 2'b10);
      check_eq({tag, " held quad"}, o_rsp_quad, exp_q);
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    check_eq({tag, " post valid/ready"}, {o_rsp_valid, o_req_ready}, 2'b01);
    check_eq({tag, " cs total"}, cs_cnt[0] + cs_cnt[1] + cs_cnt[2] - base_tot, exp_cs);
    if (bank < 2'd3) check_eq({tag, " cs bank"}, cs_cnt[bank] - base[bank], exp_cs);
    check_eq({tag, " multi cs"}, multi_cs - base_multi, 0);
    if (!exp_err && wr) ref_arr[key] = quad;
  endtask

  initial begin
    int cnt;
    logic [63:0] q;
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_bank = 2'd0;
    i_req_addr = '0; i_req_quad = '0; i_rsp_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_eq("reset ready/valid/err", {o_req_ready, o_rsp_valid, o_rsp_err}, 3'b100);
    check_eq("reset selects/wr", {o_mem_cs_ram, o_mem_cs_rom0, o_mem_cs_rom1, o_mem_wr}, 4'b0);
    check_eq("reset addr/field/data", {o_mem_addr, o_mem_field, o_mem_data}, 0);
    check_eq("reset quad", o_rsp_quad, 0);

    do_req(1'b1, 2'd0, 12'h123, 64'h4444_3333_2222_1111, 0, "wr ram");
    do_req(1'b0, 2'd0, 12'h123, 64'h0, 0, "rd ram");
    do_req(1'b0, 2'd3, 12'h001, 64'h0, 0, "rd illegal");
    do_req(1'b1, 2'd1, 12'h005, 64'hA5A5_5A5A_0F0F_F0F0, 0, "wr rom0");
    do_req(1'b0, 2'd1, 12'h005, 64'h0, 0, "rd rom0");
    do_req(1'b1, 2'd2, 12'h006, 64'h1234_5678_9ABC_DEF0, 0, "wr rom1");
    do_req(1'b0, 2'd2, 12'h006, 64'h0, 0, "rd rom1");
    do_req(1'b0, 2'd0, 12'h123, 64'h0, 10, "rd stall");

    // Reset during ISSUE field 2
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_bank = 2'd0; i_req_addr = 12'h123;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    check_eq("mid field", {o_mem_cs_ram, o_mem_field}, 3'b110);
    i_rst_n = 1'b0;
    #1;
    check_eq("rst selects", {o_mem_cs_ram, o_mem_cs_rom0, o_mem_cs_rom1, o_mem_wr}, 4'b0);
    check_eq("rst ready/valid", {o_req_ready, o_rsp_valid}, 2'b10);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (o_rsp_valid) cnt++;
    end
    check_eq("no rsp after reset", cnt, 0);
    check_eq("ready after reset", o_req_ready, 1);

    // Back-to-back writes with the response side always ready
    q = 64'hCAFE_BABE_DEAD_BEEF;
    @(negedge i_clk);
    i_rsp_ready = 1'b1; i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_bank = 2'd0;
    i_req_addr = 12'h200; i_req_quad = q;
    cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge i_clk);
      if (o_rsp_valid) cnt++;
    end
    i_req_valid = 1'b0;
    check_eq("b2b write count", cnt, 10);
    repeat (8) @(negedge i_clk);
    i_rsp_ready = 1'b0;
    ref_arr[int'(12'h200)] = q;
    do_req(1'b0, 2'd0, 12'h200, 64'h0, 0, "rd b2b");

    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 12'h010 + 12'($urandom_range(0, 3)),
             {$urandom, $urandom}, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
